// File: rtl/mul_share_arbiter.sv
// mul_share_arbiter
//   Several requesters share one signed fixed-point multiplier. A round-robin
//   arbiter issues at most one operation per cycle. The result comes back on a
//   shared bus a fixed number of cycles later, tagged with a one-hot owner pulse.
//
// Parameters
//   width_H  signed integer bits of the fixed-point format
//   width_W  fraction bits (data width D = width_H + width_W)
//   num_ch   number of requesters (2..8)
//   mul_lat  cycles from grant to result pulse (1..4)
//
// Ports
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   req_en    per-channel request, held until granted
//   req_a     channel k operand A at [k*D +: D], two's complement
//   req_b     channel k operand B, same packing
//   req_gnt   combinational one-hot grant; operands are taken on that edge
//   rsp_en    registered one-hot pulse naming the owner of rsp_data
//   rsp_data  registered product, held between pulses
//   busy      high while any operation occupies the multiply pipeline
module mul_share_arbiter #(
    parameter int width_H = 5,
    parameter int width_W = 20,
    parameter int num_ch  = 4,
    parameter int mul_lat = 2
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic [num_ch-1:0]                     req_en,
    input  logic [num_ch*(width_H+width_W)-1:0]   req_a,
    input  logic [num_ch*(width_H+width_W)-1:0]   req_b,
    output logic [num_ch-1:0]                     req_gnt,
    output logic [num_ch-1:0]                     rsp_en,
    output logic [width_H+width_W-1:0]            rsp_data,
    output logic                                  busy
);

    localparam int D  = width_H + width_W;
    localparam int PW = $clog2(num_ch);

    // ------------------------------------------------------------------
    // Round-robin arbiter
    // ------------------------------------------------------------------
    logic [PW-1:0]     ptr_q;
    logic [PW-1:0]     ptr_d;
    logic [num_ch-1:0] gnt_d;
    logic [PW-1:0]     gnt_idx;
    logic              gnt_any;

    // Search upward from ptr_q, wrapping; the first active request wins.
    always_comb begin
        gnt_d   = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        for (int i = 0; i < num_ch; i++) begin
            if (!gnt_any && req_en[(int'(ptr_q) + i) % num_ch]) begin
                gnt_any = 1'b1;
                gnt_idx = PW'((int'(ptr_q) + i) % num_ch);
            end
        end
        // No grant may be seen by a requester while the block is in reset,
        // otherwise it would believe its operands were consumed.
        if (!rst_n) begin
            gnt_any = 1'b0;
        end
        if (gnt_any) begin
            gnt_d[gnt_idx] = 1'b1;
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (gnt_any) begin
            ptr_d = (gnt_idx == PW'(num_ch - 1)) ? '0 : gnt_idx + PW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign req_gnt = gnt_d;

    // ------------------------------------------------------------------
    // Shared multiplier
    // ------------------------------------------------------------------
    logic        [D-1:0]         op_a;
    logic        [D-1:0]         op_b;
    logic signed [D+width_W-1:0] op_a_x;
    logic signed [D+width_W-1:0] op_b_x;
    logic        [D-1:0]         prod;

    assign op_a = req_a[gnt_idx*D +: D];
    assign op_b = req_b[gnt_idx*D +: D];

    // Only the low D+width_W product bits survive the shift-and-truncate,
    // so the multiply is carried out at that width; the integer part wraps.
    assign op_a_x = {{width_W{op_a[D-1]}}, op_a};
    assign op_b_x = {{width_W{op_b[D-1]}}, op_b};
    assign prod   = D'((op_a_x * op_b_x) >>> width_W);

    // ------------------------------------------------------------------
    // Result pipeline: valid bit, one-hot owner tag and product per stage.
    // The tag is all-zero for an empty stage, so the last stage's tag is the
    // rsp_en pulse directly. Data only loads when a valid entry arrives,
    // which makes rsp_data hold between pulses.
    // ------------------------------------------------------------------
    logic [mul_lat-1:0] vld_vec;

    for (genvar gi = 0; gi < mul_lat; gi++) begin : g_pipe
        logic              vld_in;
        logic [num_ch-1:0] tag_in;
        logic [D-1:0]      dat_in;
        logic              vld_q;
        logic [num_ch-1:0] tag_q;
        logic [D-1:0]      dat_q;

        if (gi == 0) begin : g_first
            assign vld_in = gnt_any;
            assign tag_in = gnt_d;
            assign dat_in = prod;
        end else begin : g_next
            assign vld_in = g_pipe[gi-1].vld_q;
            assign tag_in = g_pipe[gi-1].tag_q;
            assign dat_in = g_pipe[gi-1].dat_q;
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                vld_q <= 1'b0;
                tag_q <= '0;
                dat_q <= '0;
            end else begin
                vld_q <= vld_in;
                tag_q <= tag_in;
                if (vld_in) begin
                    dat_q <= dat_in;
                end
            end
        end

        assign vld_vec[gi] = vld_q;
    end

    assign rsp_en   = g_pipe[mul_lat-1].tag_q;
    assign rsp_data = g_pipe[mul_lat-1].dat_q;
    assign busy     = |vld_vec;

endmodule

// File: doc/mul_share_arbiter.md
MUL_SHARE_ARBITER -- requirements
Module: mul_share_arbiter

Interface
REQ-001 Parameter width_H, default 5, meaning signed integer bits of the fixed-point format.
REQ-002 Parameter width_W, default 20, meaning fraction bits; data width D = width_H+width_W.
REQ-003 Parameter num_ch, default 4, meaning requester count, legal range 2..8.
REQ-004 Parameter mul_lat, default 2, meaning result latency in cycles from grant to rsp_en, legal range 1..4.
REQ-005 clk  input  1  rising-edge clock, sole clock.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 req_en  input  num_ch  per-channel request, held high until granted.
REQ-008 req_a  input  num_ch*D  channel k operand A at bits [k*D +: D], signed two's complement.
REQ-009 req_b  input  num_ch*D  channel k operand B, same packing.
REQ-010 req_gnt  output  num_ch  combinational grant, one-hot or zero; operands are captured in the same cycle.
REQ-011 rsp_en  output  num_ch  registered one-hot pulse marking the result owner.
REQ-012 rsp_data  output  D  registered shared product bus.
REQ-013 busy  output  1  high while any operation is in the multiply pipeline.

Function
REQ-014 One shared signed multiplier; at most one operation issued per cycle.
REQ-015 Arbitration is round-robin: search starts at pointer ptr and proceeds upward modulo num_ch; the first channel with req_en=1 is granted.
REQ-016 After a grant to channel k, ptr becomes (k+1) mod num_ch on the next edge; with no request, ptr is unchanged and nothing is issued.
REQ-017 req_gnt[k] is asserted only when req_en[k]=1; a requester seeing req_gnt[k]=1 treats its operands as consumed on that edge.
REQ-018 Each issue carries a valid bit and a channel tag through a mul_lat-deep pipeline alongside the operands/product.
REQ-019 Result = full 2D-bit signed product, arithmetic right shift by width_W, low D bits kept; overflow wraps, no saturation, no rounding.
REQ-020 rsp_en[k] pulses exactly mul_lat cycles after the cycle in which req_gnt[k] was high, together with that operation's rsp_data.
REQ-021 Results are returned in issue order; back-to-back issues produce back-to-back rsp_en pulses.
REQ-022 rsp_data holds its last value when rsp_en is all zero.
REQ-023 busy = OR of the pipeline valid bits.
REQ-024 A channel dropping req_en before a grant is simply not served; no state is kept for it.

Reset
REQ-025 rst_n low asynchronously clears ptr to 0, all pipeline valid bits, rsp_en, and rsp_data to 0, and sets busy to 0.
REQ-026 While rst_n is low, req_gnt is forced to 0.
REQ-027 Reset mid-operation discards every in-flight result; no rsp_en is pulsed for operations issued before reset.
REQ-028 The first grant after reset release follows REQ-015 starting from channel 0.

Verification
REQ-029 Defaults: ch0 a=524288 (0.5), b=262144 (0.25) -> req_gnt=0001 the same cycle; 2 cycles later rsp_en=0001, rsp_data=131072.
REQ-030 ch2 a=-1048576 (-1.0), b=524288 (0.5) -> rsp_en=0100, rsp_data=-524288 (0x1F80000).
REQ-031 ch1 a=8388608 (8.0), b=4194304 (4.0) -> rsp_data=0 (wrap).
REQ-032 All four req_en held high for 8 cycles from reset -> grants 0,1,2,3,0,1,2,3, rsp_en sequence identical, delayed 2 cycles, with no gaps.
REQ-033 Only ch3 and ch1 request after a grant to ch2 -> ch3 is granted first, then ch1.
REQ-034 Issue to ch0 and ch1 on consecutive cycles, then assert rst_n low 1 cycle after the second issue -> no rsp_en pulses, busy=0, ptr=0 after release.
